// File: rtl/debounce_pkg.sv
// Shared types and defaults for the contact debouncer.
// State encoding and the default acceptance window live here so the bench and RTL agree.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    localparam int DEFAULT_STABLE_CYCLES = 4;

endpackage : debounce_pkg

// File: rtl/debounce_fsm_sync_2ff.sv
// Two-flop synchronizer for the raw button level; used only when DEBOUNCE_SYNC_EN is defined.
// Both flops clear asynchronously so a reset never leaves a stale sample in flight.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/debounce_fsm.sv
// Debouncer for a mechanical contact: accepts a new level after STABLE_CYCLES constant samples.
// Optional input synchronizer enabled by macro DEBOUNCE_SYNC_EN (adds two cycles of latency).
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE_LOW  | level=0 accepted, sample matches, count idle
//   WAIT_HIGH | sample went high, counting consecutive highs
//   IDLE_HIGH | level=1 accepted, sample matches, count idle
//   WAIT_LOW  | sample went low, counting consecutive lows
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   TERM = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    logic          s;
    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          level_next, rise_next, fall_next;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync_2ff (
        .clock (clock),
        .reset (reset),
        .d     (button),
        .q     (s)
    );
`else
    assign s = button;
`endif

    // The count tracks consecutive samples of the candidate level; it is
    // cleared on acceptance and on every reversal, so it tops out at TERM.
    always_comb begin
        state_next = state;
        count_next = count;
        level_next = level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        unique case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    count_next = ONE;
                end else begin
                    count_next = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                    count_next = '0;
                end else if (count == TERM) begin
                    state_next = IDLE_HIGH;
                    count_next = '0;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    count_next = ONE;
                end else begin
                    count_next = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                    count_next = '0;
                end else if (count == TERM) begin
                    state_next = IDLE_LOW;
                    count_next = '0;
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    count_next = count + ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                count_next = '0;
                level_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE_LOW;
            count <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule : debounce_fsm

// File: tb/tb_debounce_fsm.sv
// Scoreboard bench for debounce_fsm: a run-length reference model pushes expected outputs per cycle.
// Honors DEBOUNCE_SYNC_EN by modelling the two extra sample stages.
module tb_debounce_fsm;

    localparam int S = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = S + 2;
`else
    localparam int LAT = S;
`endif

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } exp_t;

    logic clock;
    logic reset;
    logic button;
    logic level, rise, fall;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    logic         m_level;
    int           m_run;
    logic         m_ff1, m_ff2;
    logic [S-1:0] hist;
    logic         prev_level;
    int           steps;
    int           first_rise;
    int           n_rise, n_fall;

    debounce_fsm #(.STABLE_CYCLES(S)) dut (
        .clock  (clock),
        .reset  (reset),
        .button (button),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    a_rose_level: assert property (@(posedge clock) disable iff (!reset) $rose(level) |-> rise)
        else chk("a_rose_level_rise", 0, 1);
    a_rise_once: assert property (@(posedge clock) disable iff (!reset) rise |=> !rise)
        else chk("a_rise_single", 0, 1);
    a_fall_once: assert property (@(posedge clock) disable iff (!reset) fall |=> !fall)
        else chk("a_fall_single", 0, 1);
    a_excl: assert property (@(posedge clock) disable iff (!reset) !(rise && fall))
        else chk("a_rise_fall_excl", 0, 1);

    task automatic model_reset();
        m_level = 1'b0;
        m_run   = 0;
        m_ff1   = 1'b0;
        m_ff2   = 1'b0;
        hist    = '0;
    endtask

    // Drive one cycle of stimulus, predict, then compare at the following negedge.
    task automatic step(input logic b);
        exp_t e;
        logic sv;
        button = b;
        e = '0;
        if (!reset) begin
            model_reset();
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            sv    = m_ff2;
            m_ff2 = m_ff1;
            m_ff1 = b;
`else
            sv = b;
`endif
            hist    = {hist[S-2:0], sv};
            e.level = m_level;
            if (sv != m_level) begin
                m_run++;
                if (m_run == S) begin
                    m_level = sv;
                    e.level = sv;
                    e.rise  = sv;
                    e.fall  = !sv;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        sb_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
        steps++;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("level", level, e.level);
            chk("rise", rise, e.rise);
            chk("fall", fall, e.fall);
        end
        if (rise) begin
            n_rise++;
            if (first_rise == 0) first_rise = steps;
        end
        if (fall) n_fall++;
        if (level !== prev_level) chk("stable_before_change", hist == {S{level}}, 1);
        prev_level = level;
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic new_scenario();
        steps      = 0;
        first_rise = 0;
        n_rise     = 0;
        n_fall     = 0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        prev_level = 1'b0;
        reset      = 1'b0;
        button     = 1'b0;
        model_reset();
        new_scenario();
        #1;
        chk("rst_level", level, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        #21 reset = 1'b1;
        step(1'b0);

        // clean press then release
        new_scenario();
        run(1'b1, 10);
        chk("press_latency", first_rise, LAT);
        chk("press_rise_count", n_rise, 1);
        chk("press_no_fall", n_fall, 0);
        chk("press_level", level, 1);
        new_scenario();
        run(1'b0, 8);
        chk("release_fall_count", n_fall, 1);
        chk("release_level", level, 0);

        // short dropout while high, then a real release
        run(1'b1, 8);
        new_scenario();
        run(1'b0, 3);
        run(1'b1, 3);
        chk("dropout_no_fall", n_fall, 0);
        chk("dropout_level", level, 1);
        new_scenario();
        run(1'b0, 6);
        chk("long_low_fall_count", n_fall, 1);
        chk("long_low_level", level, 0);

        // bounce pattern
        run(1'b0, 4);
        new_scenario();
        begin
            logic [10:0] pat;
            pat = 11'b111_0_11_0_1111;
            for (int i = 10; i >= 0; i--) step(pat[i]);
        end
        run(1'b1, 3);
        chk("bounce_rise_count", n_rise, 1);
        chk("bounce_rise_at", first_rise, 11 + LAT - S);
        run(1'b0, 8);

        // reset during WAIT_HIGH with button held
        new_scenario();
        run(1'b1, 2);
        reset = 1'b0;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_rise", rise, 0);
        step(1'b1);
        chk("midrst_no_rise", n_rise, 0);
        reset = 1'b1;
        new_scenario();
        run(1'b1, 8);
        chk("post_rst_latency", first_rise, LAT);
        chk("post_rst_rise_count", n_rise, 1);
        run(1'b0, 8);

        // randomized bouncy traffic against the model
        for (int i = 0; i < 300; i++) step(1'(($urandom_range(0, 9) < 6) ? m_level ^ 1'b1 : m_level));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        chk("timeout", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule : tb_debounce_fsm
